// File: rtl/bemf_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bemf_sampler_pkg
//  Description : Shared types and constants for the back-EMF sampler:
//                FSM state encoding, ADC result width, motor count and the
//                motor/channel index type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package bemf_sampler_pkg;

    localparam int ADC_W   = 10;
    localparam int NUM_MOT = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } bemf_state_t;

    localparam chan_t C_LAST_CHAN = chan_t'(NUM_MOT - 1);

endpackage
`default_nettype wire

// File: rtl/bemf_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bemf_sampler_if
//  Description : Signal bundle between the back-EMF sampler and its
//                environment (motor driver, shared ADC, register bus).
//  Modports    : master - the sampler (drives blanking, ADC requests,
//                         results and flags)
//                slave  - the environment (enable, ADC reply, flag clear)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bemf_sampler_if;
    import bemf_sampler_pkg::*;

    logic               enable;
    logic               bemf_sensing;
    logic               adc_go;
    chan_t              adc_chan;
    logic [ADC_W-1:0]   adc_data;
    logic               adc_valid;
    logic [ADC_W-1:0]   bemf0;
    logic [ADC_W-1:0]   bemf1;
    logic [ADC_W-1:0]   bemf2;
    logic [ADC_W-1:0]   bemf3;
    logic               bemf_update;
    logic [NUM_MOT-1:0] timeout_flags;
    logic               clear_flags;

    modport master (
        input  enable, adc_data, adc_valid, clear_flags,
        output bemf_sensing, adc_go, adc_chan, bemf0, bemf1, bemf2, bemf3,
               bemf_update, timeout_flags
    );

    modport slave (
        output enable, adc_data, adc_valid, clear_flags,
        input  bemf_sensing, adc_go, adc_chan, bemf0, bemf1, bemf2, bemf3,
               bemf_update, timeout_flags
    );

endinterface
`default_nettype wire

// File: rtl/bemf_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bemf_period_timer
//  Description : Free-running period counter, 0..PERIOD_CYCLES-1, held at 0
//                while disabled. wrap_o is high during the cycle in which the
//                counter rolls over to 0.
//  Ports       : clk, reset (sync, active high)
//                enable_i  - count enable; low clears and holds the count
//                wrap_o    - one-cycle rollover strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module bemf_period_timer #(
    parameter int PERIOD_CYCLES = 260000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic wrap_o
);

    localparam int               CNT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             w_wrap;

    always_comb begin
        w_wrap = enable_i && (count_q == C_LAST);
        if (!enable_i || w_wrap) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wrap_o = w_wrap;

endmodule
`default_nettype wire

// File: rtl/bemf_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : bemf_sampler
//  Description : Periodic back-EMF sampler. Each period wrap it blanks the
//                PWM (bemf_sensing), waits for coil current to decay, then
//                converts the four motor channels on the shared ADC and
//                latches the results. Per-motor sticky flags record ADC
//                timeouts.
//  Ports       : clk, reset (sync, active high)
//                bus (master) - enable, blanking, ADC request/reply,
//                               results, update pulse, timeout flags
//  Revision    : 1.0 - initial release
// ============================================================================
module bemf_sampler
    import bemf_sampler_pkg::*;
#(
    parameter int PERIOD_CYCLES = 260000,
    parameter int SETTLE_CYCLES = 2600,
    parameter int ADC_TIMEOUT   = 1024
) (
    input  logic           clk,
    input  logic           reset,
    bemf_sampler_if.master bus
);

    localparam int               SET_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int               TMO_W         = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] C_SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST    = TMO_W'(ADC_TIMEOUT - 1);

    bemf_state_t        state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    chan_t              chan_q, chan_d;
    logic [NUM_MOT-1:0] flags_q, flags_d;
    logic [ADC_W-1:0]   bemf_q [NUM_MOT];

    logic               w_wrap;
    logic               w_capture;
    logic               w_timeout;

    bemf_period_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_period_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (bus.enable),
        .wrap_o   (w_wrap)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        chan_d    = chan_q;
        w_capture = 1'b0;
        w_timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A wrap seen outside IDLE is simply lost: rounds never queue.
                if (w_wrap) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == C_SETTLE_LAST) begin
                    state_d = ST_REQ;
                    chan_d  = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                // A reply landing on the expiry cycle still counts as good.
                if (bus.adc_valid) begin
                    w_capture = 1'b1;
                    state_d   = ST_NEXT;
                end else if (tmo_q == C_TMO_LAST) begin
                    w_timeout = 1'b1;
                    state_d   = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if (chan_q == C_LAST_CHAN) begin
                    state_d = ST_DONE;
                end else begin
                    chan_d  = chan_q + chan_t'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing enable abandons the round; any in-flight conversion is
        // dropped without capture or flag.
        if (!bus.enable) begin
            state_d   = ST_IDLE;
            w_capture = 1'b0;
            w_timeout = 1'b0;
        end
    end

    // A timeout being recorded wins over a simultaneous clear.
    always_comb begin
        flags_d = bus.clear_flags ? '0 : flags_q;
        if (w_timeout) begin
            flags_d[chan_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            chan_q   <= '0;
            flags_q  <= '0;
            for (int i = 0; i < NUM_MOT; i++) begin
                bemf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            chan_q   <= chan_d;
            flags_q  <= flags_d;
            for (int i = 0; i < NUM_MOT; i++) begin
                if (w_capture && (chan_q == chan_t'(i))) begin
                    bemf_q[i] <= bus.adc_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign bus.bemf_sensing  = (state_q == ST_SETTLE) || (state_q == ST_REQ) ||
                               (state_q == ST_WAIT)   || (state_q == ST_NEXT);
    assign bus.adc_go        = (state_q == ST_REQ);
    assign bus.adc_chan      = chan_q;
    assign bus.bemf_update   = (state_q == ST_DONE);
    assign bus.timeout_flags = flags_q;
    assign bus.bemf0         = bemf_q[0];
    assign bus.bemf1         = bemf_q[1];
    assign bus.bemf2         = bemf_q[2];
    assign bus.bemf3         = bemf_q[3];

endmodule
`default_nettype wire

// File: tb/tb_bemf_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bemf_sampler
//  Description : Self-checking bench for bemf_sampler. A round schedule is
//                derived arithmetically from ADC latencies (settle time,
//                per-motor wait = latency or timeout, two overhead cycles
//                per motor) and compared cycle by cycle with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bemf_sampler;
    import bemf_sampler_pkg::*;

    localparam int P = 200;
    localparam int S = 10;
    localparam int T = 16;

    typedef logic [3:0][7:0]       lat4_t;   // 0 = ADC never answers
    typedef logic [3:0][ADC_W-1:0] dat4_t;

    typedef struct packed {
        lat4_t      lat;
        dat4_t      dat;
        logic [3:0] flags;   // flags after the round, before clearing
        logic [7:0] len;     // cycles from sensing rise to update pulse
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bemf_sampler_if bus();

    bemf_sampler #(
        .PERIOD_CYCLES (P),
        .SETTLE_CYCLES (S),
        .ADC_TIMEOUT   (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    int               epoch;
    lat4_t            lat_cfg;
    dat4_t            dat_cfg;
    bit               reply_pend;
    int               reply_cyc;
    logic [ADC_W-1:0] reply_dat;
    logic [ADC_W-1:0] exp_bemf [4];
    logic [3:0]       exp_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [ADC_W-1:0] dut_bemf(input int i);
        case (i)
            0:       return bus.bemf0;
            1:       return bus.bemf1;
            2:       return bus.bemf2;
            default: return bus.bemf3;
        endcase
    endfunction

    function automatic lat4_t mk_lat(input int a, input int b, input int c, input int d);
        lat4_t r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    function automatic dat4_t mk_dat(input int a, input int b, input int c, input int d);
        dat4_t r;
        r[0] = ADC_W'(a); r[1] = ADC_W'(b); r[2] = ADC_W'(c); r[3] = ADC_W'(d);
        return r;
    endfunction

    // Advance one clock; inputs then apply to the next edge. The ADC model
    // answers lat cycles after it sees adc_go.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        if (reply_pend && cyc == reply_cyc) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = reply_dat;
            reply_pend    = 1'b0;
        end
        if (bus.adc_go) begin
            int c;
            c = int'(bus.adc_chan);
            if (lat_cfg[c] != 8'd0) begin
                reply_pend = 1'b1;
                reply_cyc  = cyc + int'(lat_cfg[c]);
                reply_dat  = dat_cfg[c];
            end
        end
    endtask

    function automatic int next_rise();
        int r;
        r = epoch + P;
        while (r - 6 <= cyc) r += P;
        return r;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) chk({tag, "_bemf"}, 32'(dut_bemf(i)), 32'(exp_bemf[i]));
        chk({tag, "_flags"}, 32'(bus.timeout_flags), 32'(exp_flags));
    endtask

    task automatic clear_pulse();
        tick();
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        exp_flags = 4'b0000;
        chk("clear_flags", 32'(bus.timeout_flags), 32'(exp_flags));
    endtask

    // Run one round whose sensing rises at 'rise'. abort_at >= 0 drops
    // enable during that cycle. len_meas = update cycle - rise, or -1.
    task automatic run_round(input int rise, input lat4_t lat, input dat4_t dat,
                             input int abort_at, input bit stray, output int len_meas);
        int  go_c [4];
        int  fin  [4];
        bit  tmo  [4];
        int  done, sense_end, last_c;
        bit  aborted, exp_go;
        go_c[0] = rise + S;
        for (int i = 0; i < 4; i++) begin
            tmo[i] = (lat[i] == 8'd0);
            fin[i] = go_c[i] + (tmo[i] ? T : int'(lat[i]));
            if (i < 3) go_c[i+1] = fin[i] + 2;
        end
        done      = fin[3] + 2;
        aborted   = (abort_at >= 0) && (abort_at < done);
        sense_end = aborted ? abort_at + 1 : done;
        last_c    = aborted ? abort_at + 12 : done + 1;
        lat_cfg   = lat;
        dat_cfg   = dat;
        len_meas  = -1;
        while (cyc < last_c) begin
            tick();
            if (stray && (cyc == rise - 5 || cyc == rise + 3)) begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = '1;
            end
            if (aborted && cyc == abort_at) bus.enable = 1'b0;
            exp_go = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (cyc == go_c[i] && (!aborted || cyc <= abort_at)) exp_go = 1'b1;
                if (cyc >= go_c[i] && cyc <= fin[i] && (!aborted || cyc <= abort_at))
                    chk("adc_chan", 32'(bus.adc_chan), 32'(i));
            end
            chk("bemf_sensing", 32'(bus.bemf_sensing), 32'(cyc >= rise && cyc < sense_end));
            chk("adc_go", 32'(bus.adc_go), 32'(exp_go));
            chk("bemf_update", 32'(bus.bemf_update), 32'(!aborted && cyc == done));
            if (bus.bemf_update) len_meas = cyc - rise;
            if (stray && cyc == rise + 5) check_regs("stray");
        end
        for (int i = 0; i < 4; i++) begin
            if (aborted && fin[i] >= abort_at) continue;
            if (tmo[i]) exp_flags[i] = 1'b1;
            else        exp_bemf[i]  = dat[i];
        end
        check_regs("round");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [5];
        int    rise, len, go1;
        lat4_t rl;
        dat4_t rd;

        tbl[0] = '{lat: mk_lat(3, 3, 3, 3),   dat: mk_dat('h100, 'h101, 'h102, 'h103), flags: 4'b0000, len: 8'd30};
        tbl[1] = '{lat: mk_lat(3, 3, 0, 3),   dat: mk_dat('h200, 'h201, 'h202, 'h203), flags: 4'b0100, len: 8'd43};
        tbl[2] = '{lat: mk_lat(3, 16, 3, 3),  dat: mk_dat('h300, 'h301, 'h302, 'h303), flags: 4'b0000, len: 8'd43};
        tbl[3] = '{lat: mk_lat(1, 16, 0, 5),  dat: mk_dat('h3AA, 'h155, 'h2F0, 'h0F0), flags: 4'b0100, len: 8'd56};
        tbl[4] = '{lat: mk_lat(0, 0, 0, 0),   dat: mk_dat('h011, 'h022, 'h033, 'h044), flags: 4'b1111, len: 8'd82};

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.adc_valid   = 1'b0;
        bus.adc_data    = '0;
        bus.clear_flags = 1'b0;
        reply_pend      = 1'b0;
        lat_cfg         = mk_lat(3, 3, 3, 3);
        dat_cfg         = '0;
        exp_flags       = 4'b0000;
        for (int i = 0; i < 4; i++) exp_bemf[i] = '0;

        tick(); tick(); tick();
        chk("rst_sensing", 32'(bus.bemf_sensing), 32'd0);
        chk("rst_go", 32'(bus.adc_go), 32'd0);
        chk("rst_chan", 32'(bus.adc_chan), 32'd0);
        chk("rst_update", 32'(bus.bemf_update), 32'd0);
        check_regs("rst");

        reset      = 1'b0;
        bus.enable = 1'b1;
        epoch      = cyc;

        // Table-driven rounds
        for (int k = 0; k < 5; k++) begin
            rise = next_rise();
            run_round(rise, tbl[k].lat, tbl[k].dat, -1, (k == 2), len);
            chk("round_len", 32'(len), 32'(tbl[k].len));
            chk("tbl_flags", 32'(bus.timeout_flags), 32'(tbl[k].flags));
            clear_pulse();
        end

        // Abort while waiting on motor 1; its late reply must be ignored
        rise = next_rise();
        go1  = rise + S + 5;
        run_round(rise, mk_lat(3, 8, 3, 3), mk_dat('h055, 'h066, 'h077, 'h088), go1 + 4, 1'b0, len);
        chk("abort_no_update", 32'(len), 32'hFFFF_FFFF);
        bus.enable = 1'b1;
        epoch      = cyc;
        rise       = next_rise();
        chk("reenable_delay", 32'(rise - epoch), 32'(P));
        run_round(rise, mk_lat(2, 4, 6, 3), mk_dat('h1A1, 'h1B2, 'h1C3, 'h1D4), -1, 1'b0, len);
        chk("reenable_len", 32'(len), 32'(S + 4 + 6 + 8 + 5));

        // Leave a flag set, then reset in the middle of SETTLE
        rise = next_rise();
        run_round(rise, mk_lat(3, 3, 3, 0), mk_dat('h0AB, 'h0CD, 'h0EF, 'h012), -1, 1'b0, len);
        rise = next_rise();
        while (cyc < rise + 4) begin
            tick();
            if (cyc == rise) chk("pre_reset_sensing", 32'(bus.bemf_sensing), 32'd1);
        end
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        reply_pend = 1'b0;
        exp_flags  = 4'b0000;
        for (int i = 0; i < 4; i++) exp_bemf[i] = '0;
        chk("mid_rst_sensing", 32'(bus.bemf_sensing), 32'd0);
        chk("mid_rst_go", 32'(bus.adc_go), 32'd0);
        chk("mid_rst_chan", 32'(bus.adc_chan), 32'd0);
        chk("mid_rst_update", 32'(bus.bemf_update), 32'd0);
        check_regs("mid_rst");
        epoch = cyc;
        rise  = next_rise();
        run_round(rise, mk_lat(3, 3, 3, 3), mk_dat('h100, 'h101, 'h102, 'h103), -1, 1'b0, len);
        chk("post_rst_len", 32'(len), 32'd30);

        // Randomized rounds against the schedule model
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                int l;
                l     = int'($urandom_range(0, T + 3));
                rl[i] = (l > T) ? 8'd0 : 8'(l);
                rd[i] = ADC_W'($urandom);
            end
            rise = next_rise();
            run_round(rise, rl, rd, -1, 1'($urandom_range(0, 1)), len);
            if ($urandom_range(0, 1) == 1) clear_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
